// File: rtl/sseg.sv
// Seven-segment glyph renderer: colours the current pixel white when it lies
// inside a lit segment of this instance's glyph, black (0) everywhere else.
module sseg #(
  parameter int X = 25,
  parameter int Y = 0,
  parameter int W = 60,
  parameter int H = 160,
  parameter int T = 10
) (
  input  logic       dclk,
  input  logic       clr,
  input  logic [7:0] bcd,
  input  logic [9:0] x,
  input  logic [9:0] y,
  output logic [2:0] r,
  output logic [2:0] g,
  output logic [2:0] b
);

  localparam logic [11:0] XP   = 12'(X);
  localparam logic [11:0] YP   = 12'(Y);
  localparam logic [11:0] WP   = 12'(W);
  localparam logic [11:0] HP   = 12'(H);
  localparam logic [11:0] TP   = 12'(T);
  localparam logic [11:0] WMT  = 12'(W - T);
  localparam logic [11:0] WPT  = 12'(W + T);
  localparam logic [11:0] HMT  = 12'(H - T);
  localparam logic [11:0] H2   = 12'(H / 2);
  localparam logic [11:0] GLO  = 12'(H / 2 - T / 2);
  localparam logic [11:0] GHI  = 12'(H / 2 + T / 2);

  logic [11:0] xe, ye, u, v;
  logic        in_org;
  logic        hu_mid, hu_left, hu_right, hu_dp;
  logic        vv_top, vv_mid, vv_bot, vv_upper, vv_lower;
  logic [7:0]  seg_hit;
  logic        pix_on;

  // Widened before subtracting so wrapped porch values (e.g. 1020) stay
  // large positive numbers and fall outside the box instead of going negative.
  always_comb begin
    xe     = {2'b00, x};
    ye     = {2'b00, y};
    in_org = (xe >= XP) && (ye >= YP);
    u      = xe - XP;
    v      = ye - YP;

    hu_mid   = (u >= TP)  && (u < WMT);
    hu_left  = (u < TP);
    hu_right = (u >= WMT) && (u < WP);
    hu_dp    = (u >= WP)  && (u < WPT);

    vv_top   = (v < TP);
    vv_mid   = (v >= GLO) && (v < GHI);
    vv_bot   = (v >= HMT) && (v < HP);
    vv_upper = (v >= TP)  && (v < H2);
    vv_lower = (v >= H2)  && (v < HMT);

    seg_hit    = 8'h00;
    seg_hit[0] = vv_top   && hu_mid;
    seg_hit[1] = vv_upper && hu_right;
    seg_hit[2] = vv_lower && hu_right;
    seg_hit[3] = vv_bot   && hu_mid;
    seg_hit[4] = vv_lower && hu_left;
    seg_hit[5] = vv_upper && hu_left;
    seg_hit[6] = vv_mid   && hu_mid;
    seg_hit[7] = vv_bot   && hu_dp;

    pix_on = in_org && |(seg_hit & ~bcd);
  end

  always_ff @(posedge dclk) begin
    if (clr) begin
      r <= 3'b000;
      g <= 3'b000;
      b <= 3'b000;
    end else begin
      r <= {3{pix_on}};
      g <= {3{pix_on}};
      b <= {3{pix_on}};
    end
  end

endmodule

// File: tb/tb_sseg.sv
// Directed bench for sseg with default geometry; each response is sampled
// one cycle after its stimulus.
module tb_sseg;

  logic       dclk = 1'b0;
  logic       clr;
  logic [7:0] bcd;
  logic [9:0] x;
  logic [9:0] y;
  logic [2:0] r, g, b;

  int pass_cnt  = 0;
  int total_cnt = 0;

  localparam logic [8:0] ON  = 9'h1FF;
  localparam logic [8:0] OFF = 9'h000;

  sseg dut (
    .dclk(dclk), .clr(clr), .bcd(bcd), .x(x), .y(y),
    .r(r), .g(g), .b(b)
  );

  always #20 dclk = ~dclk;

  task automatic drive(input logic c, input logic [7:0] pat,
                       input int xi, input int yi);
    clr = c;
    bcd = pat;
    x   = 10'(xi);
    y   = 10'(yi);
  endtask

  task automatic step_check(input string tag, input logic [8:0] exp);
    logic [8:0] obs;
    @(posedge dclk);
    #1;
    obs = {r, g, b};
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: rgb observed %h expected %h", tag, obs, exp);
  endtask

  initial begin
    drive(1'b1, 8'h00, 50, 5);
    for (int i = 0; i < 3; i++) step_check("reset_hold", OFF);
    drive(1'b0, 8'h00, 50, 5);
    step_check("reset_release", ON);

    drive(1'b1, 8'h00, 50, 5);
    step_check("reset_midframe", OFF);
    drive(1'b0, 8'h00, 50, 5);
    step_check("reset_resume", ON);

    for (int yy = 0; yy < 2; yy++) begin
      for (int xx = 0; xx < 640; xx++) begin
        drive(1'b0, 8'hFF, xx, (yy == 0) ? 5 : 80);
        step_check("blank_sweep", OFF);
      end
    end

    drive(1'b0, 8'hFE, 50, 5);   step_check("a_lit", ON);
    drive(1'b0, 8'hFE, 30, 5);   step_check("a_corner", OFF);
    drive(1'b0, 8'hFE, 50, 80);  step_check("a_only_no_g", OFF);

    drive(1'b0, 8'h80, 55, 80);  step_check("eight_g", ON);
    drive(1'b0, 8'h80, 55, 40);  step_check("eight_interior", OFF);
    drive(1'b0, 8'h80, 25, 40);  step_check("eight_f_u0", ON);
    drive(1'b0, 8'h80, 24, 40);  step_check("eight_left_of_box", OFF);
    drive(1'b0, 8'h80, 55, 155); step_check("eight_d", ON);
    drive(1'b0, 8'h80, 25, 155); step_check("eight_corner_bl", OFF);
    drive(1'b0, 8'h80, 26, 120); step_check("eight_e", ON);
    drive(1'b0, 8'h80, 84, 120); step_check("eight_c", ON);

    drive(1'b0, 8'hFD, 84, 40);  step_check("b_u59", ON);
    drive(1'b0, 8'hFD, 85, 40);  step_check("b_right_edge", OFF);
    drive(1'b0, 8'hFD, 84, 10);  step_check("b_v_t", ON);
    drive(1'b0, 8'hFD, 84, 9);   step_check("b_corner", OFF);
    drive(1'b0, 8'hFD, 84, 80);  step_check("b_not_lower", OFF);

    drive(1'b0, 8'h7F, 90, 155); step_check("dp_lit", ON);
    drive(1'b0, 8'h7F, 90, 149); step_check("dp_above", OFF);
    drive(1'b0, 8'h7F, 95, 155); step_check("dp_u70", OFF);
    drive(1'b0, 8'h7F, 55, 155); step_check("dp_only_no_d", OFF);
    drive(1'b0, 8'h00, 1020, 1020); step_check("wrap_xy", OFF);
    drive(1'b0, 8'h00, 50, 1020);   step_check("wrap_y", OFF);
    drive(1'b0, 8'h00, 1020, 5);    step_check("wrap_x", OFF);

    drive(1'b0, 8'hBF, 55, 80);  step_check("g_only_lit", ON);
    drive(1'b0, 8'hFF, 55, 80);  step_check("pattern_change_off", OFF);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
